multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences a multicycle RISC-V RV32I-subset datapath (single shared memory, instruction register, ALUOut/OldPC/Data holding registers) through fetch, decode, execute, memory and writeback steps. It decodes opcode and function fields, drives every mux select and write enable in the datapath, and counts retired instructions. Unsupported opcodes halt the core in a trap state until reset.

## Interface
- (no parameters)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 PC, 1 result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- illegal  out  1  high while in TRAP
- instret  out  32  retired-instruction count
- state_dbg  out  4  current state encoding

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
- Transitions: FETCH→DECODE. DECODE by op: 0000011/0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL; any other→TRAP. MEMADR: lw→MEMREAD, sw→MEMWRITE. MEMREAD→MEMWB. EXECUTER/EXECUTEI/JAL→ALUWB. MEMWB/MEMWRITE/ALUWB/BEQ→FETCH. TRAP→TRAP.
- Moore outputs per state (unlisted signals 0; ALUOp add unless stated):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, PCWrite 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01 (branch/jump target into ALUOut).
  - MEMADR: ALUSrcA 10, ALUSrcB 01.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, PCWrite = Zero (only Mealy term).
  - JAL: ALUSrcA 01, ALUSrcB 10, ResultSrc 00, PCWrite 1.
  - TRAP: all enables 0, illegal 1.
- ALU decode (ALUOp funct): funct3 000 → sub if op[5]&funct7b5 else add; 010 → slt; 110 → or; 111 → and; other funct3 → add.
- ImmSrc combinational from op: 0100011→01, 1100011→10, 1101111→11, all else 00.
- instret: +1 on clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ (taken or not); 32-bit wrap 0xFFFFFFFF→0; holds in TRAP.

## Timing
- Reset low (async): state←FETCH, instret←0 immediately; while reset low PCWrite, IRWrite, RegWrite, MemWrite forced 0; other outputs at FETCH values. First fetch occurs on first rising edge after reset high.
- Reset mid-instruction aborts it; no further write enables that cycle; instret not incremented.
- Cycles per instruction (FETCH inclusive): lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Decode inputs (op, funct3, funct7b5) sampled only in DECODE/MEMADR/EXECUTE*; IR is stable after FETCH.
- Zero sampled combinationally in BEQ only.

## Test plan
- Reset, then op=0000011: states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc 01; instret 0→1 after 5 cycles.
- op=0110011, funct3=000, funct7b5=1: EXECUTER ALUControl=001; funct7b5=0 → 000; funct3=111 → 010; ALUWB RegWrite=1.
- op=1100011, Zero=1 in BEQ → PCWrite=1; Zero=0 → PCWrite=0; both return to FETCH, instret +1, ImmSrc=10.
- op=0100011: MEMWRITE asserts MemWrite=1, AdrSrc=1, ImmSrc=01; 4-cycle instruction; RegWrite never 1.
- op=0000000 at DECODE → TRAP (state_dbg=11, illegal=1), stays 10+ cycles with all enables 0; reset low→FETCH, illegal=0.
- Force instret to 0xFFFFFFFF (run/preload), retire addi → instret=0; assert reset during MEMREAD → state 0 asynchronously, MemWrite/RegWrite stay 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for a multicycle RV32I-subset datapath
//
// Sequences a shared-memory multicycle datapath through fetch, decode,
// execute, memory and writeback steps, drives every mux select and write
// enable, and counts retired instructions. Unsupported opcodes park the
// controller in TRAP until reset.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   op          Instr[6:0] from the instruction register
//   funct3      Instr[14:12]
//   funct7b5    Instr[30]
//   Zero        ALU zero flag, used only while resolving a branch
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0 PC, 1 result
//   MemWrite    memory write enable
//   IRWrite     instruction register / OldPC enable
//   ResultSrc   00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     00 rs2, 01 ImmExt, 10 constant 4
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc      00 I, 01 S, 10 B, 11 J
//   RegWrite    register file write enable
//   illegal     high while in TRAP
//   instret     retired-instruction count (wraps at 2^32)
//   state_dbg   current state encoding

module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [31:0] instret_q;
  logic [1:0]  alu_op;
  logic        pc_write_raw;
  logic        ir_write_raw;
  logic        reg_write_raw;
  logic        mem_write_raw;
  logic        branch;
  logic        retire;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      // Only lw and sw reach MEMADR, so the store opcode alone separates them.
      S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_JAL:      next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      // Encodings 12-15 are unreachable; treat them as a fault and halt.
      default:    next_state = S_TRAP;
    endcase
  end

  // Moore outputs per state
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    branch        = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = ALUOP_ADD;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        // OldPC + imm is precomputed into ALUOut for branches and jumps.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        ResultSrc = 2'b00;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        ResultSrc     = 2'b00;
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc     = 2'b00;
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_SUB;
        ResultSrc = 2'b00;
        branch    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b00;
        pc_write_raw = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are gated by reset so an in-flight write dies with it.
  assign PCWrite  = reset & (pc_write_raw | (branch & Zero));
  assign IRWrite  = reset & ir_write_raw;
  assign RegWrite = reset & reg_write_raw;
  assign MemWrite = reset & mem_write_raw;

  // ALU decoder
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; addi ignores it.
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

  // Immediate format select, purely from the opcode
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // An instruction retires on the edge that leaves its last state.
  assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                  (state == S_ALUWB) || (state == S_BEQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret   = instret_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller

module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        adr;
    logic        mw;
    logic        irw;
    logic [1:0]  rs;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  alu;
    logic [1:0]  imm;
    logic        rw;
    logic        ill;
    logic [31:0] ir;
  } exp_t;

  exp_t        q[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_ir;
  event        chk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .illegal    (illegal),
    .instret    (instret),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a state, written from the per-state output table.
  function automatic exp_t model(input logic [3:0] st, input logic zero,
                                 input logic [2:0] aluc, input logic [1:0] imm,
                                 input logic rst_low);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.imm = imm;
    e.ir  = exp_ir;
    case (st)
      4'd0:  begin e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.adr = 1'b1; end
      4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.sb = 2'b00; e.alu = aluc; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = aluc; end
      4'd8:  begin e.rw = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = zero; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd11: begin e.ill = 1'b1; end
      default: begin end
    endcase
    if (rst_low) begin
      e.pcw = 1'b0;
      e.irw = 1'b0;
      e.rw  = 1'b0;
      e.mw  = 1'b0;
    end
    return e;
  endfunction

  // One clock cycle in state st; called at posedge+1.
  task automatic cyc(input logic [3:0] st, input logic zero,
                     input logic [2:0] aluc, input logic [1:0] imm);
    Zero = zero;
    q.push_back(model(st, zero, aluc, imm, 1'b0));
    if (st == 4'd4 || st == 4'd5 || st == 4'd8 || st == 4'd9)
      exp_ir = exp_ir + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // One instruction; seq holds the hand-listed state walk, first state in the low nibble.
  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic zero, input logic [2:0] aluc, input logic [1:0] imm,
                       input logic [23:0] seq, input int n);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    for (int i = 0; i < n; i++) cyc(seq[4*i +: 4], zero, aluc, imm);
  endtask

  // Immediate check while reset is held low, off the clock edge.
  task automatic async_check(input logic [1:0] imm);
    q.push_back(model(4'd0, 1'b0, 3'b000, imm, 1'b1));
    ->chk;
  endtask

  // Monitor: pops one expectation whenever the DUT outputs are sampled.
  initial begin
    forever begin
      @(negedge clk or chk);
      if (q.size() > 0) begin
        exp_t e;
        exp_t a;
        e = q.pop_front();
        a = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal, instret};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ctl_outputs #%0d t=%0t: actual st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ill=%b instret=%h | required st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ill=%b instret=%h",
                   n_checks, $time, a.st, a.pcw, a.adr, a.mw, a.irw, a.rs, a.sa, a.sb, a.alu, a.imm, a.rw, a.ill, a.ir,
                   e.st, e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb, e.alu, e.imm, e.rw, e.ill, e.ir);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ir   = 32'd0;
    reset    = 1'b0;
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    Zero     = 1'b0;

    // Held in reset: FETCH encodings with all enables low, count zero.
    #1;
    q.push_back(model(4'd0, 1'b0, 3'b000, 2'b00, 1'b1));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    //     op          f3      f7    Z     ALUCtl  Imm    states     n
    instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 24'h043210, 5); // lw
    instr(7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 24'h008610, 4); // sub
    instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 24'h008610, 4); // add
    instr(7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 24'h008610, 4); // and
    instr(7'b0110011, 3'b110, 1'b1, 1'b0, 3'b011, 2'b00, 24'h008610, 4); // or
    instr(7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00, 24'h008610, 4); // slt
    instr(7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 24'h008710, 4); // addi, f7b5 ignored
    instr(7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00, 24'h008710, 4); // slti
    instr(7'b0010011, 3'b100, 1'b0, 1'b0, 3'b000, 2'b00, 24'h008710, 4); // other funct3 -> add
    instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, 2'b10, 24'h000910, 3); // beq taken
    instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b10, 24'h000910, 3); // beq not taken
    instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 24'h005210, 4); // sw
    instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b11, 24'h008A10, 4); // jal

    // Counter wrap: preload all-ones, retire one addi.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_ir = 32'hFFFF_FFFF;
    instr(7'b0010011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 24'h008710, 4);
    instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 24'h008610, 4);

    // Reset asserted in the middle of MEMREAD.
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    cyc(4'd0, 1'b0, 3'b000, 2'b00);
    cyc(4'd1, 1'b0, 3'b000, 2'b00);
    cyc(4'd2, 1'b0, 3'b000, 2'b00);
    q.push_back(model(4'd3, 1'b0, 3'b000, 2'b00, 1'b0));
    #6;
    reset  = 1'b0;
    exp_ir = 32'd0;
    #1;
    async_check(2'b00);
    @(posedge clk);
    #1;
    q.push_back(model(4'd0, 1'b0, 3'b000, 2'b00, 1'b1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    instr(7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 24'h008610, 4);

    // Unsupported opcode: halt in TRAP, then recover through reset.
    op       = 7'b0000000;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    cyc(4'd0, 1'b0, 3'b000, 2'b00);
    cyc(4'd1, 1'b0, 3'b000, 2'b00);
    for (int i = 0; i < 12; i++) cyc(4'd11, 1'b1, 3'b000, 2'b00);
    reset  = 1'b0;
    exp_ir = 32'd0;
    #1;
    async_check(2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    instr(7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011, 2'b00, 24'h008710, 4);

    // Let the monitor drain; a stuck queue counts as a failure.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
